anfsqrt_sqrt_seq: RTL and testbench
===================================

ANFSQRT_SQRT_SEQ -- requirements
Module: anfsqrt_sqrt_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, radicand width; even, >= 4; N = WIDTH/2.
REQ-002 SHALL have parameter ROUND_EN, default 1; 0 forces floor mode and ties in_round low internally.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  radicand offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a radicand.
REQ-007 SHALL have port in_data  input  WIDTH  unsigned radicand x.
REQ-008 SHALL have port in_round  input  1  1 = round-to-nearest, 0 = floor; sampled with in_data.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_root  output  N  integer square root.
REQ-012 SHALL have port out_rem  output  N+1  x - floor_root^2, always the floor remainder.
REQ-013 SHALL have port out_sat  output  1  rounded root saturated.
REQ-014 SHALL have port busy  output  1  high in CALC or DONE.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; IDLE after reset.
REQ-016 SHALL drive in_ready = (state == IDLE) and rst_n high; combinational.
REQ-017 SHALL, on an edge with in_valid && in_ready, capture in_data and in_round, clear root and remainder, load iteration counter to N-1, enter CALC.
REQ-018 SHALL, on each CALC edge, perform one radix-4 restoring step: rem = (rem<<2) | next two MSBs of x; trial = (root<<2) | 1; if rem >= trial then rem -= trial and root = (root<<1)|1, else root = root<<1.
REQ-019 SHALL hold the working remainder in N+2 bits with no overflow for any x.
REQ-020 SHALL leave CALC for DONE on the edge where the counter is 0, i.e. after exactly N steps; out_valid rises N cycles after the acceptance edge.
REQ-021 SHALL, in round mode, apply on the final step: if floor remainder > floor root, out_root = floor root + 1, else floor root.
REQ-022 SHALL, when the rounded root would equal 2^N, output all-ones and set out_sat; out_sat is 0 in floor mode.
REQ-023 SHALL hold out_root, out_rem, out_sat and out_valid stable in DONE while out_ready is low.
REQ-024 SHALL return to IDLE on an edge with out_valid && out_ready; out_valid falls that edge.
REQ-025 SHALL ignore in_valid in CALC and DONE; no acceptance in the same cycle as result handoff; minimum spacing between acceptances N+2 cycles.
REQ-026 SHALL keep out_root/out_rem/out_sat at their last values in IDLE and CALC; they are meaningful only with out_valid.

Reset
REQ-027 SHALL, on any edge with rst_n low, including mid-CALC or in DONE, enter IDLE and clear out_valid, out_root, out_rem, out_sat, busy, counter and working registers; no partial result emitted.
REQ-028 SHALL accept a new radicand on the first edge after rst_n returns high if in_valid is high.

Structure
REQ-029 SHALL place the state encodings (IDLE=0, CALC=1, DONE=2) in the shared header anfsqrt_defs.vh used by all anfsqrt blocks.
REQ-030 SHALL implement the per-step arithmetic of REQ-018 as one combinational sub-module anfsqrt_sqrt_step, parametrised by N.
REQ-031 SHALL keep counter width clog2(N).

Verification
REQ-032 SHALL check: WIDTH=32, x=0, floor -> out_root 0, out_rem 0, out_valid exactly 16 cycles after acceptance.
REQ-033 SHALL check: x=65536 floor -> root 256, rem 0; x=65535 floor -> root 255, rem 510.
REQ-034 SHALL check round mode: x=12 -> root 3 (rem 3); x=13 -> root 4, rem 4, out_sat 0.
REQ-035 SHALL check: x=0xFFFFFFFF, round -> out_root 0xFFFF, out_rem 131070, out_sat 1; floor -> same root, out_sat 0.
REQ-036 SHALL check backpressure: out_ready low 5 cycles in DONE with in_valid high -> outputs stable, in_ready low, no new acceptance; handoff, then IDLE next cycle.
REQ-037 SHALL check reset at step 7 of CALC -> next cycle IDLE, out_valid 0, in_ready 1 after rst_n high, next radicand 144 -> root 12, rem 0.

Source files
------------

// File: rtl/anfsqrt_sqrt_seq_pkg.sv
// Shared definitions for the anfsqrt square-root blocks.
// Holds the controller state encoding: IDLE = 0, CALC = 1, DONE = 2.
package anfsqrt_sqrt_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } sqrt_state_e;

endpackage : anfsqrt_sqrt_seq_pkg

// File: rtl/anfsqrt_sqrt_step.sv
// One radix-4 restoring square-root step (purely combinational).
// Ports:
//   rem_i  [N+1:0] working remainder before the step
//   root_i [N-1:0] partial root before the step
//   bits_i [1:0]   next two radicand bits, MSB first
//   rem_o  [N+1:0] working remainder after the step
//   root_o [N-1:0] partial root after the step (one more bit)
module anfsqrt_sqrt_step #(
    parameter int N = 16
) (
    input  logic [N+1:0] rem_i,
    input  logic [N-1:0] root_i,
    input  logic [1:0]   bits_i,
    output logic [N+1:0] rem_o,
    output logic [N-1:0] root_o
);

    logic [N+1:0] rem_sh;
    logic [N+1:0] trial;
    logic         ge;

    always_comb begin
        // The remainder never exceeds 2*root, so shifting it left by two
        // and appending two bits always fits in N+2 bits.
        rem_sh = (rem_i << 2) | (N+2)'(bits_i);
        trial  = ((N+2)'(root_i) << 2) | (N+2)'(1);
        ge     = (rem_sh >= trial);
        rem_o  = ge ? (rem_sh - trial) : rem_sh;
        root_o = (root_i << 1) | N'(ge);
    end

endmodule : anfsqrt_sqrt_step

// File: rtl/anfsqrt_sqrt_seq.sv
// Sequential integer square root, one result bit per clock.
// Accepts an unsigned WIDTH-bit radicand, runs N = WIDTH/2 restoring
// radix-4 steps, then presents floor or rounded root plus floor remainder.
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready     radicand handshake; in_data radicand, in_round mode
//   out_valid/out_ready   result handshake
//   out_root [N-1:0]      root (floor, or rounded when in_round was set)
//   out_rem  [N:0]        x - floor_root^2
//   out_sat               rounded root clipped to all-ones
//   busy                  high while computing or holding a result
module anfsqrt_sqrt_seq
    import anfsqrt_sqrt_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit ROUND_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] out_root,
    output logic [WIDTH/2:0]   out_rem,
    output logic               out_sat,
    output logic               busy
);

    localparam int N     = WIDTH / 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    sqrt_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] x_q;
    logic [N+1:0]     rem_q;
    logic [N-1:0]     root_q;
    logic             rnd_q;
    logic             out_valid_q;
    logic [N-1:0]     out_root_q;
    logic [N:0]       out_rem_q;
    logic             out_sat_q;

    logic [N+1:0]     rem_d;
    logic [N-1:0]     root_d;

    // Returns {sat, root}. Rounding up is needed exactly when the floor
    // remainder exceeds the floor root (x >= r^2 + r + 1 > (r + 0.5)^2).
    function automatic logic [N:0] round_root(input logic [N-1:0] root,
                                              input logic [N+1:0] rem,
                                              input logic         en);
        logic [N:0] res;
        res = {1'b0, root};
        if (en && (rem > (N+2)'(root))) begin
            if (&root) res = {1'b1, root};
            else       res = {1'b0, root + N'(1)};
        end
        return res;
    endfunction

    anfsqrt_sqrt_step #(.N(N)) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (x_q[WIDTH-1 -: 2]),
        .rem_o  (rem_d),
        .root_o (root_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            rnd_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_root_q  <= '0;
            out_rem_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_data;
                        rnd_q   <= in_round & ROUND_EN;
                        rem_q   <= '0;
                        root_q  <= '0;
                        cnt_q   <= CNT_W'(N - 1);
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    x_q    <= x_q << 2;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        {out_sat_q, out_root_q} <= round_root(root_d, rem_d, rnd_q);
                        out_rem_q   <= (N+1)'(rem_d);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && rst_n;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_root  = out_root_q;
    assign out_rem   = out_rem_q;
    assign out_sat   = out_sat_q;

endmodule : anfsqrt_sqrt_seq

// File: tb/tb_anfsqrt_sqrt_seq.sv
module tb_anfsqrt_sqrt_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_round;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_root;
    logic [16:0] out_rem;
    logic        out_sat;
    logic        busy;

    int tests = 0;
    int fails = 0;

    anfsqrt_sqrt_seq #(.WIDTH(32), .ROUND_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_round  (in_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .out_rem   (out_rem),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: greedy bit-by-bit search for the largest r with r*r <= x.
    task automatic model(input logic [31:0] x, input logic rnd,
                         output logic [63:0] root, output logic [63:0] rem,
                         output logic [63:0] sat);
        longint unsigned r, t, xv;
        xv = longint'(x);
        r  = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= xv) r = t;
        end
        rem  = xv - r * r;
        root = r;
        sat  = 0;
        if (rnd && rem > r) begin
            if (r + 1 == 65536) sat = 1;
            else root = r + 1;
        end
    endtask

    // Offer one radicand with out_ready high and check result, latency, handoff.
    task automatic run(input logic [31:0] x, input logic rnd,
                       input logic [63:0] e_root, input logic [63:0] e_rem,
                       input logic [63:0] e_sat, input string tag);
        int lat;
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        in_round = rnd;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'd16);
        chk({tag, ".root"}, 64'(out_root), e_root);
        chk({tag, ".rem"},  64'(out_rem),  e_rem);
        chk({tag, ".sat"},  64'(out_sat),  e_sat);
        @(posedge clk);
        #1;
        chk({tag, ".handoff_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".handoff_idle"},  64'(in_ready),  64'd1);
    endtask

    initial begin
        logic [31:0] x;
        logic        r;
        logic [63:0] er, em, es;
        logic [15:0] held_root;
        logic [16:0] held_rem;
        int          k;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_round  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.busy",      64'(busy),      64'd0);
        chk("reset.in_ready",  64'(in_ready),  64'd0);
        chk("reset.root",      64'(out_root),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready_released", 64'(in_ready), 64'd1);

        // Directed values
        run(32'd0,          1'b0, 64'd0,     64'd0,      64'd0, "x0_floor");
        run(32'd65536,      1'b0, 64'd256,   64'd0,      64'd0, "x65536");
        run(32'd65535,      1'b0, 64'd255,   64'd510,    64'd0, "x65535");
        run(32'd12,         1'b1, 64'd3,     64'd3,      64'd0, "x12_round");
        run(32'd13,         1'b1, 64'd4,     64'd4,      64'd0, "x13_round");
        run(32'hFFFF_FFFF,  1'b1, 64'hFFFF,  64'd131070, 64'd1, "xmax_round");
        run(32'hFFFF_FFFF,  1'b0, 64'hFFFF,  64'd131070, 64'd0, "xmax_floor");

        // Backpressure: result held, new offers ignored
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd65535;
        in_round = 1'b0;
        @(posedge clk);
        #1;
        in_data = 32'd4;
        k = 0;
        while (!out_valid && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp.latency", 64'(k), 64'd16);
        held_root = out_root;
        held_rem  = out_rem;
        chk("bp.root", 64'(held_root), 64'd255);
        chk("bp.rem",  64'(held_rem),  64'd510);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold_valid", 64'(out_valid), 64'd1);
            chk("bp.hold_root",  64'(out_root),  64'(held_root));
            chk("bp.hold_rem",   64'(out_rem),   64'(held_rem));
            chk("bp.in_ready",   64'(in_ready),  64'd0);
            chk("bp.busy",       64'(busy),      64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp.handoff_valid", 64'(out_valid), 64'd0);
        chk("bp.handoff_idle",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        chk("bp.no_accept", 64'(busy), 64'd0);

        // Reset in the middle of CALC
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        in_round = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.busy",      64'(busy),      64'd0);
        chk("rst_mid.out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid.root",      64'(out_root),  64'd0);
        chk("rst_mid.rem",       64'(out_rem),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
        run(32'd144, 1'b0, 64'd12, 64'd0, 64'd0, "x144_after_reset");

        // Randomized radicands against the reference
        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 0) x = 32'($urandom_range(0, 400));
            else            x = $urandom;
            r = 1'($urandom_range(0, 1));
            model(x, r, er, em, es);
            run(x, r, er, em, es, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_anfsqrt_sqrt_seq
